// File: rtl/board_cursor_ctrl.sv
// Board cursor control: conditions three raw push-buttons and holds cursor/selection for the 8x8 renderer.
// Latency: button edge to press pulse 2+DEBOUNCE_CYCLES+1 cycles; state moves on the edge ending the vsync-fall cycle.
// Backpressure: none; presses coalesce into sticky request flags that wait for the next vsync commit.
module board_cursor_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int NUM_COLUMNS     = 8,
   parameter int NUM_ROWS        = 8
) (
   input  logic       vgaclk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       btn_right_n,
   input  logic       btn_down_n,
   input  logic       btn_select_n,
   output logic [2:0] cursor_col,
   output logic [2:0] cursor_row,
   output logic       sel_valid,
   output logic [2:0] sel_col,
   output logic [2:0] sel_row,
   output logic       pending
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       COL_LAST = 3'(NUM_COLUMNS - 1);
   localparam logic [2:0]       ROW_LAST = 3'(NUM_ROWS - 1);

   // Button lanes inside the packed vectors below.
   localparam int BTN_R = 0;
   localparam int BTN_D = 1;
   localparam int BTN_S = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   logic [1:0]       r_rst_sync;
   logic             w_rst_n;
   logic [2:0]       w_btn_raw;
   logic [2:0]       r_sync1;
   logic [2:0]       r_sync2;
   logic [2:0]       r_deb;
   logic [2:0]       r_deb_q;
   logic [2:0]       r_press;
   logic [CNT_W-1:0] r_cnt [3];
   logic [2:0]       r_req;
   logic             r_vsync_q;
   logic             w_vs_fall;
   logic             w_commit;
   state_t           r_state;
   logic [2:0]       r_cursor_col;
   logic [2:0]       r_cursor_row;
   logic             r_sel_valid;
   logic [2:0]       r_sel_col;
   logic [2:0]       r_sel_row;
   logic [2:0]       w_col_next;
   logic [2:0]       w_row_next;
   logic             w_sel_hit;

   // Reset asserts asynchronously and releases two clean clock edges later.
   always_ff @(posedge vgaclk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n   = r_rst_sync[1];
   assign w_btn_raw = {btn_select_n, btn_down_n, btn_right_n};

   // Two-flop synchroniser per button; idle level is released (1).
   always_ff @(posedge vgaclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sync1 <= 3'b111;
         r_sync2 <= 3'b111;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: the synced level must differ for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
   always_ff @(posedge vgaclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_deb <= 3'b111;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Registered one-cycle press pulse on a debounced 1->0 transition; releases are ignored.
   always_ff @(posedge vgaclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_deb_q <= 3'b111;
         r_press <= 3'b000;
      end else begin
         r_deb_q <= r_deb;
         r_press <= r_deb_q & ~r_deb;
      end
   end

   // vsync history for falling-edge detection; starts high so reset release never looks like an edge.
   always_ff @(posedge vgaclk or negedge w_rst_n) begin
      if (!w_rst_n) r_vsync_q <= 1'b1;
      else          r_vsync_q <= vsync;
   end

   assign w_vs_fall = r_vsync_q & ~vsync;
   assign w_commit  = (r_state == ST_IDLE) & w_vs_fall;

   // Sticky request flags: cleared by a commit, but a pulse landing on the commit cycle survives to the next one.
   always_ff @(posedge vgaclk or negedge w_rst_n) begin
      if (!w_rst_n)      r_req <= 3'b000;
      else if (w_commit) r_req <= r_press;
      else               r_req <= r_req | r_press;
   end

   assign w_col_next = (r_cursor_col == COL_LAST) ? 3'd0 : r_cursor_col + 3'd1;
   assign w_row_next = (r_cursor_row == ROW_LAST) ? 3'd0 : r_cursor_row + 3'd1;
   assign w_sel_hit  = r_sel_valid && (r_sel_col == r_cursor_col) && (r_sel_row == r_cursor_row);

   // Commit FSM: applies every pending request at once on the vsync fall, using the pre-move cursor for select.
   always_ff @(posedge vgaclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= ST_IDLE;
         r_cursor_col <= 3'd0;
         r_cursor_row <= 3'd0;
         r_sel_valid  <= 1'b0;
         r_sel_col    <= 3'd0;
         r_sel_row    <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_vs_fall) begin
                  r_state <= ST_COMMIT;
                  if (r_req[BTN_R]) r_cursor_col <= w_col_next;
                  if (r_req[BTN_D]) r_cursor_row <= w_row_next;
                  if (r_req[BTN_S]) begin
                     if (w_sel_hit) begin
                        r_sel_valid <= 1'b0;
                     end else begin
                        r_sel_valid <= 1'b1;
                        r_sel_col   <= r_cursor_col;
                        r_sel_row   <= r_cursor_row;
                     end
                  end
               end
            end
            ST_COMMIT: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign cursor_col = r_cursor_col;
   assign cursor_row = r_cursor_row;
   assign sel_valid  = r_sel_valid;
   assign sel_col    = r_sel_col;
   assign sel_row    = r_sel_row;
   assign pending    = |r_req;

endmodule
